bcau_adjust_unit: RTL and testbench

Parametrised brightness/contrast adjust unit for the BCAU pipeline. It accepts one frame of NUM_PIX pixels, LANES pixels per beat, and buffers the frame while summing intensities. It then computes the frame average with a sequential divider. Finally it replays the buffered frame, pushing each pixel away from the average by a runtime delta with saturation. The unit is multi-lane, adds valid/ready handshaking, a runtime delta and a bypass mode.

---
 rtl/bcau_pkg.sv | 28 ++
 rtl/bcau_seq_div.sv | 78 +++++++
 rtl/bcau_adjust_unit.sv | 212 +++++++++++++++++++++
 tb/tb_bcau_adjust_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcau_pkg.sv
// Shared types, constants and helpers for the BCAU brightness/contrast adjust unit.
//   bcau_adj_state_t : adjust-unit FSM states
//   BCAU_DEF_DELTA   : delta in force after reset until the first frame's first beat
//   clamp_add/sub    : saturating add/subtract for a pixel of pix_w bits
package bcau_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StDivide,
    StEmit
  } bcau_adj_state_t;

  localparam int unsigned BCAU_DEF_DELTA = 32;

  // Operands are at most 16 bits wide in practice, so 32-bit arithmetic never wraps.
  function automatic int unsigned clamp_add(int unsigned p, int unsigned d, int unsigned pix_w);
    int unsigned max_v;
    int unsigned sum;
    max_v = (32'd1 << pix_w) - 32'd1;
    sum   = p + d;
    return (sum > max_v) ? max_v : sum;
  endfunction

  function automatic int unsigned clamp_sub(int unsigned p, int unsigned d);
    return (p > d) ? (p - d) : 32'd0;
  endfunction

endpackage

// File: rtl/bcau_seq_div.sv
// Sequential restoring divider, one quotient bit per cycle.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : pulse; captures dividend_i and begins a DividendW-cycle divide
//   dividend_i    : numerator
//   divisor_i     : denominator, must stay stable while the divide runs
//   done_o        : one-cycle pulse in the cycle after the last quotient bit
//   quotient_o    : floor(dividend / divisor), valid while done_o is high
module bcau_seq_div #(
  parameter int unsigned DividendW = 15,
  parameter int unsigned DivisorW  = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DividendW-1:0] dividend_i,
  input  logic [DivisorW-1:0]  divisor_i,
  output logic                 done_o,
  output logic [DividendW-1:0] quotient_o
);

  localparam int unsigned CntW = $clog2(DividendW + 1);

  logic [DivisorW-1:0]  rem_q, rem_d;
  logic [DividendW-1:0] quo_q, quo_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DivisorW:0]    trial;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
    trial  = {rem_q, quo_q[DividendW-1]};
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      cnt_d  = CntW'(DividendW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = quo_q << 1;
      if (trial >= {1'b0, divisor_i}) begin
        rem_d    = DivisorW'(trial - {1'b0, divisor_i});
        quo_d[0] = 1'b1;
      end else begin
        rem_d = trial[DivisorW-1:0];
      end
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/bcau_adjust_unit.sv
// Brightness/contrast adjust unit: buffers one frame while summing it, divides the sum
// by the frame size to get the average, then replays the frame pushing every pixel away
// from the average by a runtime delta with saturation.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   cfg_delta_i, cfg_bypass_i: adjust magnitude / pass-through, captured on a frame's first beat
//   in_valid_i, in_ready_o   : input handshake, in_data_i carries Lanes pixels per beat
//   out_valid_o, out_ready_i : output handshake, out_data_o same packing, out_last_o on final beat
//   avg_out_o                : most recent frame average
//   busy_o                   : high while dividing or emitting
module bcau_adjust_unit
  import bcau_pkg::*;
#(
  parameter int unsigned PixW   = 8,
  parameter int unsigned Lanes  = 4,
  parameter int unsigned NumPix = 80
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [PixW-1:0]       cfg_delta_i,
  input  logic                  cfg_bypass_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [Lanes*PixW-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [Lanes*PixW-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [PixW-1:0]       avg_out_o,
  output logic                  busy_o
);

  localparam int unsigned Depth = NumPix / Lanes;
  localparam int unsigned DivW  = $clog2(NumPix + 1);
  localparam int unsigned AccW  = PixW + DivW;
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  if ((NumPix % Lanes) != 0) begin : g_bad_cfg
    $error("NumPix must be a multiple of Lanes");
  end

  bcau_adj_state_t       state_q, state_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [PixW-1:0]       delta_q, delta_d;
  logic                  bypass_q, bypass_d;
  logic [PixW-1:0]       avg_q, avg_d;
  logic                  out_valid_q, out_valid_d;
  logic [Lanes*PixW-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  div_start_q, div_start_d;

  logic [Lanes*PixW-1:0] mem_q [Depth];
  logic [Lanes*PixW-1:0] rd_data_q;

  logic                  in_accept, out_fire, load_out;
  logic [AccW-1:0]       beat_sum;
  logic                  div_done;
  logic [AccW-1:0]       div_quo;
  logic [PixW-1:0]       adj_avg;
  logic [Lanes*PixW-1:0] adj_data;
  logic                  unused_quo;

  bcau_seq_div #(
    .DividendW(AccW),
    .DivisorW (DivW)
  ) u_div (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (div_start_q),
    .dividend_i(acc_q),
    .divisor_i (DivW'(NumPix)),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

  // Quotient is bounded by the max pixel value, so the upper bits are always zero.
  assign unused_quo = ^div_quo[AccW-1:PixW];

  assign in_accept = (state_q == StLoad) && in_valid_i;
  assign out_fire  = out_valid_q && out_ready_i;
  // Output register loads on the first beat straight out of the divider, then on every
  // handshake except the last one.
  assign load_out  = ((state_q == StDivide) && div_done) ||
                     ((state_q == StEmit) && out_fire && !out_last_q);
  // The first beat is adjusted in the same cycle the average is latched.
  assign adj_avg   = (state_q == StDivide) ? div_quo[PixW-1:0] : avg_q;

  always_comb begin
    beat_sum = '0;
    for (int unsigned l = 0; l < Lanes; l++) begin
      beat_sum += AccW'(in_data_i[l*PixW +: PixW]);
    end
  end

  always_comb begin
    adj_data = '0;
    for (int unsigned l = 0; l < Lanes; l++) begin
      if (bypass_q) begin
        adj_data[l*PixW +: PixW] = rd_data_q[l*PixW +: PixW];
      end else if (rd_data_q[l*PixW +: PixW] > adj_avg) begin
        adj_data[l*PixW +: PixW] =
            PixW'(clamp_add(32'(rd_data_q[l*PixW +: PixW]), 32'(delta_q), PixW));
      end else begin
        adj_data[l*PixW +: PixW] =
            PixW'(clamp_sub(32'(rd_data_q[l*PixW +: PixW]), 32'(delta_q)));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    acc_d       = acc_q;
    delta_d     = delta_q;
    bypass_d    = bypass_q;
    avg_d       = avg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    div_start_d = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (in_accept) begin
          acc_d = acc_q + beat_sum;
          if (wr_ptr_q == '0) begin
            delta_d  = cfg_delta_i;
            bypass_d = cfg_bypass_i;
          end
          if (wr_ptr_q == LastPtr) begin
            wr_ptr_d    = '0;
            state_d     = StDivide;
            div_start_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
          end
        end
      end
      StDivide: begin
        if (div_done) begin
          avg_d   = div_quo[PixW-1:0];
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_fire && out_last_q) begin
          state_d     = StLoad;
          acc_d       = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rd_ptr_d    = '0;
        end
      end
      default: state_d = StLoad;
    endcase

    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = adj_data;
      out_last_d  = (rd_ptr_q == LastPtr);
      rd_ptr_d    = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StLoad;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_q       <= '0;
      delta_q     <= PixW'(BCAU_DEF_DELTA);
      bypass_q    <= 1'b0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_q       <= acc_d;
      delta_q     <= delta_d;
      bypass_q    <= bypass_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      div_start_q <= div_start_d;
    end
  end

  // Frame buffer. Reading rd_ptr_d keeps rd_data_q equal to mem_q[rd_ptr_q], so the next
  // beat is always pre-fetched and output can advance every cycle.
  always_ff @(posedge clk_i) begin
    if (in_accept) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
    rd_data_q <= mem_q[rd_ptr_d];
  end

  assign in_ready_o  = (state_q == StLoad);
  assign busy_o      = (state_q != StLoad);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign avg_out_o   = avg_q;

endmodule

// File: tb/tb_bcau_adjust_unit.sv
module tb_bcau_adjust_unit;

  localparam int PixW   = 8;
  localparam int Lanes  = 4;
  localparam int NumPix = 80;
  localparam int Depth  = NumPix / Lanes;
  localparam int AccW   = PixW + $clog2(NumPix + 1);
  localparam int MaxPix = (1 << PixW) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [PixW-1:0]       cfg_delta;
  logic                  cfg_bypass;
  logic                  in_valid;
  logic                  in_ready;
  logic [Lanes*PixW-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [Lanes*PixW-1:0] out_data;
  logic                  out_last;
  logic [PixW-1:0]       avg_out;
  logic                  busy;

  bcau_adjust_unit #(
    .PixW  (PixW),
    .Lanes (Lanes),
    .NumPix(NumPix)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_delta_i (cfg_delta),
    .cfg_bypass_i(cfg_bypass),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .avg_out_o   (avg_out),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  int pix [NumPix];
  int beat_delta [Depth];
  bit frame_bypass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer average and per-pixel rule.
  function automatic int model_avg();
    int sum = 0;
    for (int i = 0; i < NumPix; i++) sum += pix[i];
    return sum / NumPix;
  endfunction

  function automatic logic [Lanes*PixW-1:0] model_beat(input int b, input int avg, input int d,
                                                       input bit byp);
    logic [Lanes*PixW-1:0] r = '0;
    for (int l = 0; l < Lanes; l++) begin
      int p = pix[b*Lanes + l];
      int o;
      if (byp) o = p;
      else if (p > avg) o = (p + d > MaxPix) ? MaxPix : p + d;
      else o = (p - d < 0) ? 0 : p - d;
      r[l*PixW +: PixW] = PixW'(o);
    end
    return r;
  endfunction

  task automatic send_frame(input int n_beats, input bit gaps);
    for (int b = 0; b < n_beats; b++) begin
      int waited = 0;
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          step();
        end
      end
      in_valid   = 1'b1;
      cfg_delta  = PixW'(beat_delta[b]);
      cfg_bypass = frame_bypass;
      for (int l = 0; l < Lanes; l++) in_data[l*PixW +: PixW] = PixW'(pix[b*Lanes + l]);
      while (!in_ready && waited < 200) begin
        step();
        waited++;
      end
      if (waited >= 200) begin
        check_eq("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_frame(input bit rand_ready);
    int avg = model_avg();
    int d   = beat_delta[0];
    bit byp = frame_bypass;
    int lat = 0;
    int beats = 0;
    int cycles = 0;
    bit stalled = 0;
    logic [Lanes*PixW-1:0] held_data = '0;
    logic held_last = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check_eq("first_out_latency", 64'(lat), 64'(AccW + 2));
    while (beats < Depth && cycles < 2000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq("out_valid_held", 64'(out_valid), 64'd1);
      check_eq("in_ready_while_busy", 64'(in_ready), 64'd0);
      check_eq("busy_while_emit", 64'(busy), 64'd1);
      if (stalled) begin
        check_eq("stall_data_stable", 64'(out_data), 64'(held_data));
        check_eq("stall_last_stable", 64'(out_last), 64'(held_last));
      end
      if (out_ready) begin
        check_eq($sformatf("beat%0d_data", beats), 64'(out_data),
                 64'(model_beat(beats, avg, d, byp)));
        check_eq($sformatf("beat%0d_last", beats), 64'(out_last), 64'(beats == Depth - 1));
        beats++;
        stalled = 0;
      end else begin
        stalled   = 1;
        held_data = out_data;
        held_last = out_last;
      end
      step();
      cycles++;
    end
    out_ready = 1'b0;
    check_eq("beat_count", 64'(beats), 64'(Depth));
    check_eq("avg_out", 64'(avg_out), 64'(avg));
    check_eq("in_ready_after_frame", 64'(in_ready), 64'd1);
    check_eq("out_valid_after_frame", 64'(out_valid), 64'd0);
    check_eq("busy_after_frame", 64'(busy), 64'd0);
  endtask

  task automatic set_delta(input int d);
    for (int b = 0; b < Depth; b++) beat_delta[b] = d;
  endtask

  task automatic rand_pix();
    for (int i = 0; i < NumPix; i++) pix[i] = $urandom_range(0, MaxPix);
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_delta  = '0;
    cfg_bypass = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    frame_bypass = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_eq("reset_in_ready", 64'(in_ready), 64'd1);
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_out_last", 64'(out_last), 64'd0);
    check_eq("reset_avg_out", 64'(avg_out), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);

    // Uniform frame: every pixel equals the average, so all go down by delta.
    for (int i = 0; i < NumPix; i++) pix[i] = 100;
    set_delta(32);
    send_frame(Depth, 0);
    recv_frame(0);
    check_eq("uniform_avg", 64'(avg_out), 64'd100);

    // Saturation at both ends.
    for (int i = 0; i < NumPix; i++) pix[i] = 0;
    pix[37] = 250;
    send_frame(Depth, 0);
    recv_frame(0);
    check_eq("sat_avg", 64'(avg_out), 64'd3);

    // Bypass.
    rand_pix();
    set_delta($urandom_range(1, MaxPix));
    frame_bypass = 1'b1;
    send_frame(Depth, 1);
    recv_frame(0);
    frame_bypass = 1'b0;

    // Backpressure on a random frame.
    rand_pix();
    set_delta($urandom_range(0, 80));
    send_frame(Depth, 1);
    recv_frame(1);

    // Reset mid-frame: partial frame must vanish without a trace.
    rand_pix();
    set_delta(40);
    send_frame(10, 0);
    for (int c = 0; c < 5; c++) begin
      check_eq("aborted_no_output", 64'(out_valid), 64'd0);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("midreset_avg_cleared", 64'(avg_out), 64'd0);
    check_eq("midreset_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < NumPix; i++) pix[i] = $urandom_range(0, 60);
    send_frame(Depth, 0);
    recv_frame(0);

    // Config is sampled only on the first beat.
    rand_pix();
    for (int b = 0; b < Depth; b++) beat_delta[b] = (b < 5) ? 16 : 64;
    send_frame(Depth, 0);
    recv_frame(0);
    rand_pix();
    set_delta(64);
    send_frame(Depth, 0);
    recv_frame(1);

    // A few mixed random frames.
    for (int f = 0; f < 3; f++) begin
      int base = $urandom_range(0, 200);
      for (int i = 0; i < NumPix; i++) pix[i] = base + $urandom_range(0, 55);
      set_delta($urandom_range(0, MaxPix));
      frame_bypass = 1'($urandom_range(0, 1));
      send_frame(Depth, 1);
      recv_frame(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
